// File: rtl/sram_burst_controller.sv
// sram_burst_controller: host-to-async-SRAM bridge splitting DW-bit words into 16-bit beats, with bursts
// and programmable read/write wait states.
module sram_burst_controller #(
  parameter int AW        = 18,
  parameter int DW        = 32,
  parameter int BURST_MAX = 4,
  parameter int RD_WAIT   = 1,
  parameter int WR_WAIT   = 0
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [AW-1:0]                i_ADDR,
  input  logic [$clog2(BURST_MAX)-1:0] i_BLEN,
  input  logic [DW-1:0]                i_WDATA,
  input  logic [DW/8-1:0]              i_BMASK,
  input  logic                         i_WREN,
  input  logic                         i_RDEN,
  output logic [DW-1:0]                o_RDATA,
  output logic                         o_RVALID,
  output logic                         o_WREADY,
  output logic                         o_ACK,
  output logic                         o_BUSY,
  output logic [AW-1:0]                SRAM_ADDR,
  inout  wire  [15:0]                  SRAM_DQ,
  output logic                         SRAM_CE_N,
  output logic                         SRAM_OE_N,
  output logic                         SRAM_WE_N,
  output logic                         SRAM_UB_N,
  output logic                         SRAM_LB_N
);
  localparam int NH = DW / 16;
  localparam int HW = NH > 1 ? $clog2(NH) : 1;
  localparam int BW = $clog2(BURST_MAX);
  typedef enum logic [2:0] {IDLE, WR_SETUP, WR_PULSE, RD_BEAT, DONE} state_t;
  state_t          r_state, w_next;
  logic [AW-1:0]   r_addr;
  logic [BW-1:0]   r_blen, r_word;
  logic [HW-1:0]   r_half;
  logic [7:0]      r_wait;
  logic [DW-1:0]   r_wdata, r_rbuf, r_rdata, w_rnext;
  logic [DW/8-1:0] r_mask;
  logic            r_rvalid;
  logic            w_idle, w_acc_wr, w_acc_rd, w_half_last, w_word_last, w_last, w_beat_end, w_wr;
  logic [1:0]      w_mask2;
  assign w_idle      = r_state == IDLE || r_state == DONE;
  assign w_acc_wr    = w_idle && i_WREN && !i_RDEN;
  assign w_acc_rd    = w_idle && i_RDEN && !i_WREN;
  assign w_half_last = r_half == HW'(NH - 1);
  assign w_word_last = r_word == r_blen;
  assign w_last      = w_half_last && w_word_last;
  assign w_beat_end  = (r_state == RD_BEAT && r_wait == 8'(RD_WAIT)) ||
                       (r_state == WR_PULSE && r_wait == 8'(WR_WAIT));
  assign w_wr        = r_state == WR_SETUP || r_state == WR_PULSE;
  assign w_mask2     = r_mask[r_half*2 +: 2];
  always_comb begin
    w_next = r_state;
    w_rnext = r_rbuf;
    w_rnext[r_half*16 +: 16] = SRAM_DQ;
    case (r_state)
      IDLE, DONE: w_next = w_acc_wr ? WR_SETUP : w_acc_rd ? RD_BEAT : IDLE;
      WR_SETUP:   w_next = WR_PULSE;
      WR_PULSE:   w_next = !w_beat_end ? WR_PULSE : w_last ? DONE : WR_SETUP;
      RD_BEAT:    w_next = w_beat_end && w_last ? DONE : RD_BEAT;
      default:    w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) r_state <= !i_reset ? IDLE : w_next;
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_addr   <= '0;
      r_blen   <= '0;
      r_word   <= '0;
      r_half   <= '0;
      r_wait   <= '0;
      r_wdata  <= '0;
      r_mask   <= '0;
      r_rbuf   <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      if (w_acc_wr || w_acc_rd) begin
        r_addr <= i_ADDR & ~AW'(NH - 1);
        r_blen <= i_BLEN;
        r_word <= '0;
        r_half <= '0;
        r_wait <= '0;
      end
      if (o_WREADY && (w_acc_wr || !w_idle)) begin
        r_wdata <= i_WDATA;
        r_mask  <= i_BMASK;
      end
      if (r_state == RD_BEAT || r_state == WR_PULSE) begin
        r_wait <= w_beat_end ? '0 : r_wait + 1'b1;
        if (w_beat_end && !w_last) begin
          r_addr <= r_addr + 1'b1;
          r_half <= w_half_last ? '0 : r_half + 1'b1;
          if (w_half_last) r_word <= r_word + 1'b1;
        end
      end
      if (r_state == RD_BEAT && w_beat_end) begin
        r_rbuf <= w_rnext;
        if (w_half_last) begin
          r_rdata  <= w_rnext;
          r_rvalid <= 1'b1;
        end
      end
    end
  end
  assign o_RDATA   = r_rdata;
  assign o_RVALID  = r_rvalid;
  assign o_ACK     = r_state == DONE;
  assign o_BUSY    = !w_idle;
  assign o_WREADY  = w_idle || (r_state == WR_PULSE && w_beat_end && w_half_last && !w_word_last);
  assign SRAM_ADDR = r_addr;
  assign SRAM_CE_N = !(w_wr || r_state == RD_BEAT);
  assign SRAM_OE_N = r_state != RD_BEAT;
  assign SRAM_WE_N = r_state != WR_PULSE;
  assign SRAM_UB_N = r_state == RD_BEAT ? 1'b0 : w_wr ? !w_mask2[1] : 1'b1;
  assign SRAM_LB_N = r_state == RD_BEAT ? 1'b0 : w_wr ? !w_mask2[0] : 1'b1;
  assign SRAM_DQ   = w_wr ? r_wdata[r_half*16 +: 16] : 16'hzzzz;
endmodule

// File: tb/tb_sram_burst_controller.sv
// tb_sram_burst_controller: two controllers (RD_WAIT=1/WR_WAIT=0 and RD_WAIT=0/WR_WAIT=1) on shared requests,
// each with its own SRAM model, checked against a reference memory and a cycle-stamped scoreboard.
module tb_sram_burst_controller;
  localparam int AW = 18;
  localparam int DW = 32;
  localparam int NH = 2;
  typedef struct {
    logic            wr;
    logic [AW-1:0]   addr;
    logic [1:0]      blen;
    logic [3:0][31:0] d;
    logic [3:0][3:0] m;
    int              lat0;
    int              lat1;
  } vec_t;
  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [AW-1:0] addr;
  logic [1:0]    blen;
  logic          wren, rden;
  logic [31:0]   wdata [2];
  logic [3:0]    bmask [2];
  logic [31:0]   rdata [2];
  logic          rvalid [2], wready [2], ack [2], busy [2];
  logic [AW-1:0] sa [2];
  logic          ce [2], oe [2], we [2], ub [2], lb [2];
  wire  [15:0]   dq0, dq1;
  logic [15:0]   mem [2][0:(1<<AW)-1];
  logic [15:0]   ref_mem [0:(1<<AW)-1];
  logic          seeded = 1'b0;
  int rd_w [2] = '{1, 0};
  int wr_w [2] = '{0, 1};
  int n_chk = 0, n_fail = 0, t0 = 0;
  int wi [2] = '{1, 1};
  vec_t cur;
  vec_t tv [9];
  exp_t rq [2][$];
  int   aq [2][$];

  sram_burst_controller #(.AW(AW), .DW(DW), .BURST_MAX(4), .RD_WAIT(1), .WR_WAIT(0)) dut0 (
    .i_clk(clk), .i_reset(rst_n), .i_ADDR(addr), .i_BLEN(blen), .i_WDATA(wdata[0]), .i_BMASK(bmask[0]),
    .i_WREN(wren), .i_RDEN(rden), .o_RDATA(rdata[0]), .o_RVALID(rvalid[0]), .o_WREADY(wready[0]),
    .o_ACK(ack[0]), .o_BUSY(busy[0]), .SRAM_ADDR(sa[0]), .SRAM_DQ(dq0), .SRAM_CE_N(ce[0]),
    .SRAM_OE_N(oe[0]), .SRAM_WE_N(we[0]), .SRAM_UB_N(ub[0]), .SRAM_LB_N(lb[0]));
  sram_burst_controller #(.AW(AW), .DW(DW), .BURST_MAX(4), .RD_WAIT(0), .WR_WAIT(1)) dut1 (
    .i_clk(clk), .i_reset(rst_n), .i_ADDR(addr), .i_BLEN(blen), .i_WDATA(wdata[1]), .i_BMASK(bmask[1]),
    .i_WREN(wren), .i_RDEN(rden), .o_RDATA(rdata[1]), .o_RVALID(rvalid[1]), .o_WREADY(wready[1]),
    .o_ACK(ack[1]), .o_BUSY(busy[1]), .SRAM_ADDR(sa[1]), .SRAM_DQ(dq1), .SRAM_CE_N(ce[1]),
    .SRAM_OE_N(oe[1]), .SRAM_WE_N(we[1]), .SRAM_UB_N(ub[1]), .SRAM_LB_N(lb[1]));

  function automatic logic [15:0] seed(int a);
    return a == 16 ? 16'hBEEF : a == 17 ? 16'hDEAD : 16'(a * 40503 ^ 21845);
  endfunction

  assign dq0 = (!ce[0] && !oe[0] && we[0]) ? mem[0][sa[0]] : 16'hzzzz;
  assign dq1 = (!ce[1] && !oe[1] && we[1]) ? mem[1][sa[1]] : 16'hzzzz;
  always @(posedge clk) begin
    if (!seeded) begin
      for (int a = 0; a < (1 << AW); a++) begin
        mem[0][a] <= seed(a);
        mem[1][a] <= seed(a);
      end
      seeded <= 1'b1;
    end else begin
      if (!ce[0] && !we[0] && !lb[0]) mem[0][sa[0]][7:0]  <= dq0[7:0];
      if (!ce[0] && !we[0] && !ub[0]) mem[0][sa[0]][15:8] <= dq0[15:8];
      if (!ce[1] && !we[1] && !lb[1]) mem[1][sa[1]][7:0]  <= dq1[7:0];
      if (!ce[1] && !we[1] && !ub[1]) mem[1][sa[1]][15:8] <= dq1[15:8];
    end
  end

  function automatic void check(string nm, logic [63:0] act, logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, want, cyc);
    end
  endfunction

  function automatic vec_t mk(logic wr, logic [AW-1:0] a, logic [1:0] b, logic [127:0] d, logic [15:0] m,
                              int l0, int l1);
    mk.wr = wr; mk.addr = a; mk.blen = b; mk.d = d; mk.m = m; mk.lat0 = l0; mk.lat1 = l1;
  endfunction

  function automatic logic [31:0] rd_word(logic [AW-1:0] a, int w);
    logic [AW-1:0] b = {a[AW-1:1], 1'b0} + AW'(2 * w);
    return {ref_mem[b + 1'b1], ref_mem[b]};
  endfunction

  // Caller aligns to just after a posedge; the current cycle is the accept cycle.
  task automatic issue(input vec_t v, input logic [1:0] en);
    exp_t e;
    logic [AW-1:0] a;
    addr = v.addr; blen = v.blen; wren = v.wr; rden = !v.wr;
    for (int d = 0; d < 2; d++) begin
      wdata[d] = v.d[0];
      bmask[d] = v.m[0];
    end
    cur = v; t0 = cyc; wi[0] = 1; wi[1] = 1;
    if (v.wr)
      for (int w = 0; w <= int'(v.blen); w++)
        for (int k = 0; k < NH; k++) begin
          a = {v.addr[AW-1:1], 1'b0} + AW'(NH * w + k);
          if (v.m[w][2*k])   ref_mem[a][7:0]  = v.d[w][16*k +: 8];
          if (v.m[w][2*k+1]) ref_mem[a][15:8] = v.d[w][16*k+8 +: 8];
        end
    for (int d = 0; d < 2; d++) if (en[d]) begin
      check($sformatf("wready_idle%0d", d), wready[d], 1);
      aq[d].push_back(cyc + (d == 0 ? v.lat0 : v.lat1));
      if (!v.wr)
        for (int w = 0; w <= int'(v.blen); w++) begin
          e.data = rd_word(v.addr, w);
          e.cyc = cyc + 1 + NH * (w + 1) * (rd_w[d] + 1);
          rq[d].push_back(e);
        end
    end
    @(posedge clk); #1;
    wren = 1'b0; rden = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy[0] || busy[1] || aq[0].size() != 0 || aq[1].size() != 0 ||
                rq[0].size() != 0 || rq[1].size() != 0) && n < 300);
    if (n >= 300) begin
      check("idle_timeout", aq[0].size() + aq[1].size() + rq[0].size() + rq[1].size(), 0);
      for (int d = 0; d < 2; d++) begin
        aq[d].delete();
        rq[d].delete();
      end
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      exp_t e;
      int c;
      if (rvalid[d]) begin
        if (rq[d].size() == 0) check($sformatf("rvalid_unexp%0d", d), rvalid[d], 0);
        else begin
          e = rq[d].pop_front();
          check($sformatf("rdata%0d", d), rdata[d], e.data);
          check($sformatf("rvalid_cyc%0d", d), cyc, e.cyc);
        end
      end
      if (ack[d]) begin
        if (aq[d].size() == 0) check($sformatf("ack_unexp%0d", d), ack[d], 0);
        else begin
          c = aq[d].pop_front();
          check($sformatf("ack_cyc%0d", d), cyc, c);
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      if (busy[d] && wready[d]) begin
        check($sformatf("wready_cyc%0d", d), cyc, t0 + NH * wi[d] * (wr_w[d] + 2));
        wdata[d] = cur.d[wi[d] & 3];
        bmask[d] = cur.m[wi[d] & 3];
        wi[d]++;
      end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    wren = 0; rden = 0; addr = '0; blen = '0;
    for (int d = 0; d < 2; d++) begin
      wdata[d] = '0;
      bmask[d] = '0;
    end
    for (int a = 0; a < (1 << AW); a++) ref_mem[a] = seed(a);
    tv[0] = mk(0, 18'h00010, 0, '0, '0, 5, 3);
    tv[1] = mk(0, 18'h3FFFE, 1, '0, '0, 9, 5);
    tv[2] = mk(0, 18'h00100, 3, '0, '0, 17, 9);
    tv[3] = mk(1, 18'h00101, 1, {64'h0, 32'hBBBB2222, 32'hAAAA1111}, 16'h00FF, 9, 13);
    tv[4] = mk(0, 18'h00100, 3, '0, '0, 17, 9);
    tv[5] = mk(1, 18'h003FE, 3, 128'h44443333_DDDDCCCC_22221111_0F0F5A5A, 16'h690F, 17, 25);
    tv[6] = mk(0, 18'h003FE, 3, '0, '0, 17, 9);
    tv[7] = mk(1, 18'h3FFFF, 0, {96'h0, 32'hCAFEF00D}, 16'h000F, 5, 7);
    tv[8] = mk(0, 18'h3FFFE, 0, '0, '0, 5, 3);
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_pins%0d", d), {ce[d], oe[d], we[d], ub[d], lb[d]}, 5'h1f);
      check($sformatf("rst_outs%0d", d), {rvalid[d], ack[d], busy[d]}, 3'b000);
      check($sformatf("rst_rdata%0d", d), rdata[d], 0);
      check($sformatf("rst_addr%0d", d), sa[d], 0);
    end
    // reset in the middle of a burst read: abort with no ack
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue(mk(0, 18'h00100, 3, '0, '0, 17, 9), 2'b11);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      rq[d].delete();
      aq[d].delete();
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("abort_pins%0d", d), {ce[d], oe[d], we[d], ub[d], lb[d]}, 5'h1f);
      check($sformatf("abort_outs%0d", d), {rvalid[d], ack[d], busy[d]}, 3'b000);
      check($sformatf("abort_rdata%0d", d), rdata[d], 0);
    end
    repeat (4) @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      issue(tv[i], 2'b11);
      wait_idle();
    end
    // byte-lane strobes of a masked single-word write at an odd address
    @(posedge clk); #1;
    issue(mk(1, 18'h00021, 0, {96'h0, 32'h12345678}, 16'h0006, 5, 7), 2'b11);
    @(negedge clk);
    check("t3_addr0", sa[0], 18'h20);
    check("t3_pins0", {ce[0], oe[0], we[0], ub[0], lb[0]}, 5'b01101);
    check("t3_dq0", dq0, 16'h5678);
    @(negedge clk);
    check("t3_we0", we[0], 0);
    @(negedge clk);
    check("t3_addr1", sa[0], 18'h21);
    check("t3_pins1", {ce[0], oe[0], we[0], ub[0], lb[0]}, 5'b01110);
    check("t3_dq1", dq0, 16'h1234);
    wait_idle();
    @(posedge clk); #1;
    issue(mk(0, 18'h00020, 0, '0, '0, 5, 3), 2'b11);
    wait_idle();
    // simultaneous read and write requests are dropped
    @(posedge clk); #1;
    wren = 1'b1; rden = 1'b1;
    @(posedge clk); #1;
    wren = 1'b0; rden = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("both_req", {busy[0], busy[1], ce[0], ce[1]}, 4'b0011);
    end
    // read accepted in DONE of dut0 while dut1 is still writing
    @(posedge clk); #1;
    issue(mk(1, 18'h00200, 0, {96'h0, 32'h600DF00D}, 16'h000F, 5, 7), 2'b11);
    repeat (4) @(posedge clk);
    #1 check("done_state0", {ack[0], busy[1]}, 2'b11);
    issue(mk(0, 18'h00200, 0, '0, '0, 5, 3), 2'b01);
    wait_idle();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
